// File: rtl/iterative_rotate_scheduler.sv
// Multi-cycle circular shifter: rotates one bit per clock, always taking the
// shorter way round, with valid/ready handshakes on both sides.
module iterative_rotate_scheduler #(
   parameter  int W  = 8,
   localparam int AW = $clog2(W)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          up_valid,
   output logic          up_ready,
   input  logic [W-1:0]  up_data,
   input  logic [AW-1:0] up_amount,
   input  logic          up_dir,
   output logic          down_valid,
   input  logic          down_ready,
   output logic [W-1:0]  down_data,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [AW:0]   W_V    = (AW+1)'(W);
   localparam logic [AW:0]   HALF_V = (AW+1)'(W / 2);
   localparam logic [AW-1:0] ONE_V  = AW'(1);
   localparam logic [AW-1:0] ZERO_V = AW'(0);

   state_t        state_r, next_state_s;
   logic [W-1:0]  data_r;
   logic [AW-1:0] cnt_r;
   logic          dir_r;
   logic          up_ready_r, down_valid_r, busy_r;

   logic [AW:0]   amt_ext_s, eff_s;
   logic [AW-1:0] steps_s;
   logic          dir_s;
   logic          accept_s, release_s;

   assign up_ready   = up_ready_r;
   assign down_valid = down_valid_r;
   assign down_data  = data_r;
   assign busy       = busy_r;

   assign accept_s  = up_valid && up_ready_r;
   assign release_s = down_valid_r && down_ready;

   // Fold amount into [0,W) and pick the shorter rotation direction
   always_comb begin
      amt_ext_s = {1'b0, up_amount};
      if (amt_ext_s >= W_V) begin
         eff_s = amt_ext_s - W_V;
      end else begin
         eff_s = amt_ext_s;
      end
      if (eff_s > HALF_V) begin
         steps_s = AW'(W_V - eff_s);
         dir_s   = ~up_dir;
      end else begin
         steps_s = eff_s[AW-1:0];
         dir_s   = up_dir;
      end
   end

   // Next-state decode
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (steps_s == ZERO_V) begin
                  next_state_s = DONE;
               end else begin
                  next_state_s = BUSY;
               end
            end else begin
               next_state_s = IDLE;
            end
         end
         BUSY: begin
            if (cnt_r == ONE_V) begin
               next_state_s = DONE;
            end else begin
               next_state_s = BUSY;
            end
         end
         DONE: begin
            if (release_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = DONE;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // State, datapath and handshake flags; flags follow the next state so they are registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         data_r       <= {W{1'b0}};
         cnt_r        <= ZERO_V;
         dir_r        <= 1'b0;
         up_ready_r   <= 1'b1;
         down_valid_r <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= next_state_s;
         up_ready_r   <= (next_state_s == IDLE);
         down_valid_r <= (next_state_s == DONE);
         busy_r       <= (next_state_s != IDLE);
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  data_r <= up_data;
                  cnt_r  <= steps_s;
                  dir_r  <= dir_s;
               end
            end
            BUSY: begin
               if (dir_r) begin
                  data_r <= {data_r[0], data_r[W-1:1]};
               end else begin
                  data_r <= {data_r[W-2:0], data_r[W-1]};
               end
               cnt_r <= cnt_r - ONE_V;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iterative_rotate_scheduler.sv
// Scoreboard bench for iterative_rotate_scheduler: expected word and latency
// queued at accept, compared when the result handshake appears.
module tb_iterative_rotate_scheduler;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         up_valid;
   logic         up_ready;
   logic [7:0]   up_data;
   logic [2:0]   up_amount;
   logic         up_dir;
   logic         down_valid;
   logic         down_ready;
   logic [7:0]   down_data;
   logic         busy;

   typedef struct {
      logic [7:0] data;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   iterative_rotate_scheduler #(.W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_data    (up_data),
      .up_amount  (up_amount),
      .up_dir     (up_dir),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_data  (down_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference rotation done the long way, in the requested direction
   function automatic logic [7:0] model_rot(input logic [7:0] d, input int k, input logic dr);
      logic [7:0] r;
      r = d;
      for (int i = 0; i < k; i++) begin
         if (dr) r = {r[0], r[7:1]};
         else    r = {r[6:0], r[7]};
      end
      return r;
   endfunction

   function automatic int model_lat(input int k);
      int e;
      e = k % W;
      return ((e > W / 2) ? (W - e) : e) + 1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One request: accept, await result, optionally stall, then handshake
   task automatic run_req(input logic [7:0] d, input logic [2:0] a, input logic dr,
                          input int hold, input logic [7:0] exp_d, input int exp_lat);
      exp_t e;
      int   lat;
      logic [7:0] held;
      check("pre_ready", up_ready, 1);
      up_valid  = 1'b1;
      up_data   = d;
      up_amount = a;
      up_dir    = dr;
      e.data = exp_d;
      e.lat  = exp_lat;
      sb.push_back(e);
      step();
      up_valid = 1'b0;
      check("acc_busy", busy, 1);
      check("acc_ready", up_ready, 0);
      lat = 1;
      while (!down_valid && lat < 20) begin
         step();
         lat++;
      end
      check("valid_timeout", down_valid, 1);
      e = sb.pop_front();
      check("data", down_data, e.data);
      check("latency", lat, e.lat);
      held = down_data;
      if (hold > 0) begin
         up_valid  = 1'b1;
         up_data   = ~d;
         up_amount = 3'd1;
         for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", down_valid, 1);
            check("hold_data", down_data, held);
            check("hold_ready", up_ready, 0);
         end
      end
      down_ready = 1'b1;
      step();
      down_ready = 1'b0;
      up_valid   = 1'b0;
      check("post_valid", down_valid, 0);
      check("post_ready", up_ready, 1);
      check("post_busy", busy, 0);
   endtask

   initial begin
      logic [7:0] rd;
      logic [2:0] ra;
      logic       rdir;
      rst        = 1'b1;
      up_valid   = 1'b0;
      up_data    = 8'h00;
      up_amount  = 3'd0;
      up_dir     = 1'b0;
      down_ready = 1'b0;
      #1;
      check("rst_valid", down_valid, 0);
      check("rst_data", down_data, 0);
      check("rst_busy", busy, 0);
      #13;
      rst = 1'b0;
      step();
      check("rst_ready", up_ready, 1);

      run_req(8'hA3, 3'd3, 1'b0, 0, 8'h1D, 4);
      run_req(8'hA3, 3'd3, 1'b1, 0, 8'h74, 4);
      run_req(8'h81, 3'd7, 1'b0, 0, 8'hC0, 2);
      run_req(8'h5A, 3'd0, 1'b0, 0, 8'h5A, 1);
      run_req(8'h96, 3'd4, 1'b1, 5, 8'h69, 5);
      run_req(8'h01, 3'd5, 1'b1, 0, 8'h08, 4);

      // Reset during the second BUSY cycle abandons the operation
      up_valid  = 1'b1;
      up_data   = 8'hFF;
      up_amount = 3'd4;
      up_dir    = 1'b0;
      step();
      up_valid = 1'b0;
      step();
      rst = 1'b1;
      #1;
      check("mid_rst_valid", down_valid, 0);
      check("mid_rst_data", down_data, 0);
      check("mid_rst_busy", busy, 0);
      #2;
      rst = 1'b0;
      step();
      check("mid_rst_ready", up_ready, 1);
      step();
      check("mid_rst_novalid", down_valid, 0);
      run_req(8'h3C, 3'd2, 1'b0, 0, 8'hF0, 3);

      for (int n = 0; n < 10; n++) begin
         rd   = 8'($urandom);
         ra   = 3'($urandom_range(0, 7));
         rdir = 1'($urandom_range(0, 1));
         run_req(rd, ra, rdir, int'($urandom_range(0, 2)),
                 model_rot(rd, int'(ra), rdir), model_lat(int'(ra)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
